// File: rtl/multiplier_divider.sv
// rtl/multiplier_divider.sv - sequential unsigned 32-bit restoring divider
// One quotient bit per clock; results held in output registers until the next result.
module multiplier_divider (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        ready,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [31:0] dq_q;
  logic [31:0] divisor_q;
  logic [32:0] prem_q;
  logic [5:0]  cnt_q;
  logic        ready_q;
  logic        done_q;
  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic        dz_q;

  logic [33:0] trial_d;
  logic [33:0] diff_d;
  logic        qbit_d;
  logic [32:0] prem_d;
  logic [31:0] dq_d;

  // prem_q[32] is always zero between iterations; it rides along as the guard bit of the compare.
  always_comb begin
    trial_d = {prem_q, dq_q[31]};
    diff_d  = trial_d - {2'b00, divisor_q};
    qbit_d  = ~diff_d[33];
    prem_d  = qbit_d ? diff_d[32:0] : trial_d[32:0];
    dq_d    = {dq_q[30:0], qbit_d};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dq_q      <= '0;
      divisor_q <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dq_q      <= in1;
            divisor_q <= in2;
            prem_q    <= '0;
            cnt_q     <= '0;
            if (in2 == 32'd0) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              quot_q  <= 32'hFFFF_FFFF;
              rem_q   <= in1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= BUSY;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        BUSY: begin
          dq_q   <= dq_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            quot_q  <= dq_d;
            rem_q   <= prem_d[31:0];
            dz_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_multiplier_divider.sv
// tb/tb_multiplier_divider.sv - scoreboard bench for multiplier_divider
// Driver pushes expected results; a negedge monitor pops and compares on each done.
module tb_multiplier_divider;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        ready;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  multiplier_divider dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .ready    (ready),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on every done, and flag any expectation whose done cycle has passed.
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", {32'd0, quotient}, {32'd0, mon_e.q});
        chk("remainder", {32'd0, remainder}, {32'd0, mon_e.r});
        chk("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
        chk("done_cycle", 64'(cyc), 64'(mon_e.at));
        if (!mon_e.dz) begin
          chk("invariant", 64'(quotient) * 64'(mon_e.b) + 64'(remainder), 64'(mon_e.a));
          chk("rem_lt_div", {63'd0, remainder < mon_e.b}, 64'd1);
        end
      end
    end else if (reset_n && sb.size() > 0 && cyc > sb[0].at) begin
      mon_e = sb.pop_front();
      chk("done_missing", 64'd0, 64'd1);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz);
    exp_t e;
    int   n;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clock);
      n = n + 1;
    end
    if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    e.a  = a;
    e.b  = b;
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    e.at = cyc + ((b == 32'd0) ? 0 : 32);
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n = n + 1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_q"}, {32'd0, quotient}, 64'd0);
    chk({tag, "_r"}, {32'd0, remainder}, 64'd0);
    chk({tag, "_dz"}, {63'd0, div_zero}, 64'd0);
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  int          busy_bad;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    in1     = '0;
    in2     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_state("reset");
    reset_n = 1'b1;

    // Basic, with start held high for part of BUSY and ready observed low throughout
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    busy_bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (ready) busy_bad = busy_bad + 1;
      start = (i < 10);
      in1   = 32'd77;
      in2   = 32'd11;
    end
    start = 1'b0;
    chk("ready_low_busy", 64'(busy_bad), 64'd0);
    drain();

    // Extremes, issued back-to-back through the DONE cycle
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    issue(32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
    drain();

    // Divide by zero, then a normal operation
    issue(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    issue(32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
    issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    drain();

    // Results hold through idle
    repeat (6) @(negedge clock);
    chk("hold_q", {32'd0, quotient}, 64'd10);
    chk("hold_r", {32'd0, remainder}, 64'd0);
    chk("hold_dz", {63'd0, div_zero}, 64'd0);
    chk("hold_ready", {63'd0, ready}, 64'd1);

    // Reset mid-operation
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    repeat (15) @(negedge clock);
    start   = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_state("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("no_done_after_reset", {32'd0, quotient}, 64'd0);
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    drain();

    // Random operands with divisor classes: random, 1, 0, power of two
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = 32'd1;
        2: rb = 32'd0;
        default: rb = 32'd1 << $urandom_range(0, 31);
      endcase
      if (rb == 32'd0) issue(ra, rb, 32'hFFFF_FFFF, ra, 1'b1);
      else issue(ra, rb, ra / rb, ra % rb, 1'b0);
    end
    drain();

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
